circuit_bist_driver: RTL and testbench

Sequential pattern driver and response compactor for the combinational 12-input / 4-output test circuits in this suite. It applies a pseudo-random pattern to every circuit input each cycle and folds the 4 circuit outputs into a 16-bit MISR signature. After a programmed number of patterns it compares the signature against a golden value and reports pass/fail. The block is the stimulus/observation end of the circuit's input/output interface and is used to check that two netlists produce identical signatures.

---
 rtl/circuit_bist_driver.sv | 98 +++++++++
 tb/tb_circuit_bist_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/circuit_bist_driver.sv
// circuit_bist_driver: LFSR pattern source and 16-bit MISR response compactor
// for 12-input / 4-output combinational test circuits.
module circuit_bist_driver #(
    parameter int          NUM_PAT    = 256,
    parameter logic [11:0] LFSR_SEED  = 12'hACE,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [11:0] pat_out,
    input  logic [3:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] pat_cnt
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [11:0] SEED = (LFSR_SEED == 12'h000) ? 12'h001 : LFSR_SEED;
    localparam logic [15:0] NPAT = 16'(NUM_PAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] lfsr;
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        busy_q;
    logic        done_q;
    logic [15:0] cnt_nx;
    logic [15:0] sig_nx;
    logic [11:0] lfsr_nx;

    // Next-step values used while running.
    always_comb begin
        cnt_nx  = cnt + 16'd1;
        sig_nx  = {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]}
                  ^ {12'h000, resp_in};
        lfsr_nx = {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
    end

    // Run-control FSM with registered status flags; start only acts outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lfsr   <= SEED;
            sig    <= 16'h0000;
            cnt    <= 16'h0000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        lfsr   <= SEED;
                        sig    <= 16'h0000;
                        cnt    <= 16'h0000;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    sig  <= sig_nx;
                    lfsr <= lfsr_nx;
                    cnt  <= cnt_nx;
                    if (cnt_nx == NPAT) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        pat_out   = busy_q ? lfsr : 12'h000;
        busy      = busy_q;
        done      = done_q;
        pass      = done_q & (sig == GOLDEN_SIG);
        signature = sig;
        pat_cnt   = cnt;
    end

endmodule

// File: tb/tb_circuit_bist_driver.sv
// tb_circuit_bist_driver: directed bench with a pattern scoreboard and a
// reference MISR/LFSR model for three parameterisations of the driver.
module tb_circuit_bist_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st = 3'b000;
    logic [3:0]  resp = 4'h0;
    logic [11:0] po [3];
    logic        bz [3];
    logic        dn [3];
    logic        ps [3];
    logic [15:0] sg [3];
    logic [15:0] pc [3];

    int nvec = 0;
    int nerr = 0;
    logic [11:0] patq [$];
    logic [15:0] fsig;

    always #5 clk = ~clk;

    circuit_bist_driver #(.NUM_PAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .pat_out(po[0]),
        .resp_in(resp), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
        .signature(sg[0]), .pat_cnt(pc[0]));

    circuit_bist_driver #(.NUM_PAT(2), .GOLDEN_SIG(16'h0010)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .pat_out(po[1]),
        .resp_in(resp), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
        .signature(sg[1]), .pat_cnt(pc[1]));

    circuit_bist_driver #(.NUM_PAT(20), .LFSR_SEED(12'h000)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .pat_out(po[2]),
        .resp_in(resp), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
        .signature(sg[2]), .pat_cnt(pc[2]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s,
                                         input logic [3:0] r);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ {12'h000, r};
    endfunction

    function automatic logic [11:0] lstep(input logic [11:0] l);
        return {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
    endfunction

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_busy"}, 32'(bz[d]), 0);
        chk({tag, "_done"}, 32'(dn[d]), 0);
        chk({tag, "_pass"}, 32'(ps[d]), 0);
        chk({tag, "_pat"},  32'(po[d]), 0);
        chk({tag, "_sig"},  32'(sg[d]), 0);
        chk({tag, "_cnt"},  32'(pc[d]), 0);
    endtask

    // One complete run on instance d; rnd selects random responses,
    // midst > 0 pulses start at that RUN edge.
    task automatic run(input int d, input int n, input logic [11:0] seed,
                       input bit rnd, input logic [3:0] r, input int midst,
                       input logic [15:0] gold, output logic [15:0] fs);
        logic [11:0] ml;
        logic [15:0] ms;
        int          mc;
        bit          fin;
        logic [11:0] exp_pat;
        resp = rnd ? 4'($urandom_range(0, 15)) : r;
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        ml = seed;
        ms = 16'h0000;
        mc = 0;
        fin = 0;
        fs = 16'h0000;
        patq.delete();
        patq.push_back(ml);
        chk("start_busy", 32'(bz[d]), 1);
        chk("start_done", 32'(dn[d]), 0);
        chk("start_sig", 32'(sg[d]), 0);
        chk("start_cnt", 32'(pc[d]), 0);
        for (int i = 1; i <= n + 4 && !fin; i++) begin
            exp_pat = patq.pop_front();
            chk("pat", 32'(po[d]), 32'(exp_pat));
            chk("pat_nz", 32'(po[d] != 12'h000), 1);
            ms = misr(ms, resp);
            ml = lstep(ml);
            mc++;
            if (mc < n) patq.push_back(ml);
            if (i == midst) st[d] = 1'b1;
            tick();
            st[d] = 1'b0;
            if (rnd) resp = 4'($urandom_range(0, 15));
            if (mc == n) begin
                fin = 1;
                chk("end_done", 32'(dn[d]), 1);
                chk("end_busy", 32'(bz[d]), 0);
                chk("end_pat", 32'(po[d]), 0);
                chk("end_cnt", 32'(pc[d]), 32'(n));
                chk("end_sig", 32'(sg[d]), 32'(ms));
                chk("end_pass", 32'(ps[d]), 32'(ms == gold));
                chk("run_edges", 32'(i + 1), 32'(n + 1));
                fs = ms;
            end else begin
                chk("run_busy", 32'(bz[d]), 1);
                chk("run_cnt", 32'(pc[d]), 32'(mc));
            end
        end
        if (!fin) chk("timeout_done", 32'(dn[d]), 1);
    endtask

    initial begin
        repeat (2) tick();
        chk_idle(0, "rst_low");
        rst_n = 1'b1;
        repeat (2) tick();
        chk_idle(1, "rst_rel");
        chk_idle(2, "rst_rel2");

        run(0, 1, 12'hACE, 0, 4'h5, 0, 16'h0000, fsig);
        chk("single_sig", 32'(fsig), 32'h0005);
        tick();
        chk("single_hold_sig", 32'(sg[0]), 32'h0005);
        chk("single_hold_done", 32'(dn[0]), 1);

        run(1, 2, 12'hACE, 0, 4'hF, 0, 16'h0010, fsig);
        chk("two_sig", 32'(fsig), 32'h0010);
        chk("two_pass", 32'(ps[1]), 1);
        run(1, 2, 12'hACE, 0, 4'hE, 0, 16'h0010, fsig);
        chk("two_e_sig", 32'(fsig), 32'h0013);
        chk("two_e_pass", 32'(ps[1]), 0);

        run(2, 20, 12'h001, 1, 4'h0, 0, 16'h0000, fsig);
        run(2, 20, 12'h001, 1, 4'h0, 5, 16'h0000, fsig);
        run(2, 20, 12'h001, 0, 4'h9, 19, 16'h0000, fsig);

        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        chk("pre_rst_busy", 32'(bz[2]), 1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk_idle(2, "async_rst");
        chk_idle(1, "async_rst1");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_idle(2, "no_resume");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
